// File: rtl/bram_host_port_pkg.sv
// rtl/bram_host_port_pkg.sv - shared processor definitions for the BRAM host port
package bram_host_port_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD      = 2'd2,
    RD_WAIT = 2'd3
  } hp_state_e;

  // Byte address = {region, word index, 2'b00}; region sits just above the word index.
  localparam int REGION_BIT_OFS = 2;

  function automatic int region_bit(input int logsize);
    return logsize + REGION_BIT_OFS;
  endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// rtl/bram_rd_fifo.sv - two-entry read-data FIFO feeding the rdata/rvalid stream
module bram_rd_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_ready_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rvalid_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             pop;

  assign rvalid_o = (count_q != 2'd0);
  assign rdata_o  = mem_q[rd_ptr_q];
  assign count_o  = count_q;
  assign pop      = rvalid_o && pop_ready_i;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop) begin
      count_d = count_q + 2'd1;
    end else if (!push_i && pop) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bram_host_port.sv
// rtl/bram_host_port.sv - host-side burst access port into the processor BRAM
module bram_host_port
  import bram_host_port_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SIZE    = 1024,
  parameter int NUM_COL = 4,
  localparam int LOGSIZE = $clog2(SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [LOGSIZE+2:0]   cmd_addr,
  input  logic [LOGSIZE:0]     cmd_len,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [NUM_COL-1:0]   wstrb,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [WIDTH-1:0]     rdata,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [WIDTH-1:0]     bram_din,
  output logic [LOGSIZE+2:0]   shared_bram_addr,
  output logic [NUM_COL-1:0]   bram_wr_en,
  input  logic [WIDTH-1:0]     bram_dout,
  output logic                 cpu_hold,
  output logic                 done
);

  localparam int AW = LOGSIZE + 3;
  localparam int LW = LOGSIZE + 1;
  localparam int RB = region_bit(LOGSIZE);

  hp_state_e        state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LW-1:0]    len_q, len_d;
  logic             inflight_q, inflight_d;
  logic             done_q, done_d;
  logic             hold_q, hold_d;

  logic [1:0]       fifo_count;
  logic [1:0]       occupancy;
  logic             beat;
  logic             issue;
  logic [LOGSIZE-1:0] word_next;
  logic [AW-1:0]    addr_next;

  // Word index wraps within the region; the region bit rides along unchanged.
  assign word_next = addr_q[RB-1:2] + LOGSIZE'(1);
  assign addr_next = {addr_q[RB], word_next, 2'b00};
  assign occupancy = fifo_count + {1'b0, inflight_q};

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    done_d     = 1'b0;
    hold_d     = hold_q;
    cmd_ready  = 1'b0;
    wready     = 1'b0;
    beat       = 1'b0;
    issue      = 1'b0;
    if (done_q) begin
      hold_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d = cmd_addr & ~AW'(3);
          len_d  = cmd_len;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            hold_d  = 1'b1;
            state_d = cmd_write ? WR : RD;
          end
        end
      end
      WR: begin
        wready = 1'b1;
        if (wvalid) begin
          beat   = 1'b1;
          addr_d = addr_next;
          len_d  = len_q - LW'(1);
          if (len_q == LW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      RD: begin
        // Never more reads outstanding than the FIFO can absorb without rready.
        if (occupancy < 2'd2) begin
          issue  = 1'b1;
          addr_d = addr_next;
          len_d  = len_q - LW'(1);
          if (len_q == LW'(1)) begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (inflight_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign inflight_d       = issue;
  assign bram_wr_en       = beat ? wstrb : '0;
  assign bram_din         = beat ? wdata : '0;
  assign shared_bram_addr = (beat || issue) ? addr_q : '0;
  assign cpu_hold         = hold_q;
  assign done             = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      hold_q     <= hold_d;
    end
  end

  bram_rd_fifo #(
    .WIDTH(WIDTH)
  ) u_rd_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .push_i      (inflight_q),
    .push_data_i (bram_dout),
    .pop_ready_i (rready),
    .rdata_o     (rdata),
    .rvalid_o    (rvalid),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_bram_host_port.sv
// tb/tb_bram_host_port.sv - directed self-checking bench for bram_host_port
module tb_bram_host_port;

  localparam int WIDTH = 32;
  localparam int SIZE = 1024;
  localparam int NUM_COL = 4;
  localparam int AW = 13;
  localparam int LW = 11;

  logic clk = 1'b0;
  logic reset;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [WIDTH-1:0] wdata;
  logic [NUM_COL-1:0] wstrb;
  logic wvalid, wready;
  logic [WIDTH-1:0] rdata;
  logic rvalid, rready;
  logic [WIDTH-1:0] bram_din, bram_dout;
  logic [AW-1:0] shared_bram_addr;
  logic [NUM_COL-1:0] bram_wr_en;
  logic cpu_hold, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bram_host_port #(.WIDTH(WIDTH), .SIZE(SIZE), .NUM_COL(NUM_COL)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .bram_din(bram_din), .shared_bram_addr(shared_bram_addr),
    .bram_wr_en(bram_wr_en), .bram_dout(bram_dout),
    .cpu_hold(cpu_hold), .done(done)
  );

  // Processor BRAM: registered read, byte-column writes. Word i preloaded with C0DE0000+i.
  logic [31:0] bmem [2048];
  initial begin
    for (int i = 0; i < 2048; i++) bmem[i] = 32'hC0DE_0000 + i;
  end
  always @(posedge clk) begin
    for (int c = 0; c < 4; c++)
      if (bram_wr_en[c]) bmem[shared_bram_addr[12:2]][c*8 +: 8] <= bram_din[c*8 +: 8];
    bram_dout <= bmem[shared_bram_addr[12:2]];
  end

  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  logic [3:0]    wr_strb_q[$];
  logic [31:0]   rd_q[$];
  int done_cnt = 0;
  int hold_cnt = 0;
  int rd_issue_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bram_wr_en != '0) begin
        wr_addr_q.push_back(shared_bram_addr);
        wr_data_q.push_back(bram_din);
        wr_strb_q.push_back(bram_wr_en);
      end
      if (bram_wr_en == '0 && shared_bram_addr != '0) rd_issue_cnt++;
      if (rvalid && rready) rd_q.push_back(rdata);
      if (done) done_cnt++;
      if (cpu_hold) hold_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (done_cnt > base) ok = 1'b1;
    end
  endtask

  task automatic wait_rd(input int target, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (rd_q.size() >= target) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL reset_wready got=%b exp=0", wready); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (bram_wr_en !== 4'h0) begin errors++; $display("FAIL reset_wr_en got=%h exp=0", bram_wr_en); end
    checks++; if (bram_din !== 32'h0) begin errors++; $display("FAIL reset_din got=%h exp=0", bram_din); end
    checks++; if (shared_bram_addr !== 13'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", shared_bram_addr); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got=%b exp=0", cpu_hold); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    reset = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write();
    int w0 = wr_addr_q.size();
    int d0 = done_cnt;
    int h0 = hold_cnt;
    bit ok;
    logic [31:0] dat [3];
    dat = '{32'hA, 32'hB, 32'hC};
    send_cmd(1'b1, 13'h000, 11'd3);
    for (int k = 0; k < 3; k++) begin
      wvalid = 1'b1; wdata = dat[k]; wstrb = 4'hF;
      tick();
    end
    wvalid = 1'b0;
    wait_done(d0, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_done_timeout got=none exp=pulse"); end
    repeat (3) tick();
    checks++; if (wr_addr_q.size() - w0 != 3) begin errors++; $display("FAIL write_beats got=%0d exp=3", wr_addr_q.size() - w0); end
    for (int k = 0; k < 3 && (w0 + k) < wr_addr_q.size(); k++) begin
      checks++; if (wr_addr_q[w0+k] !== 13'(k*4)) begin errors++; $display("FAIL write_addr%0d got=%h exp=%h", k, wr_addr_q[w0+k], k*4); end
      checks++; if (wr_data_q[w0+k] !== dat[k]) begin errors++; $display("FAIL write_data%0d got=%h exp=%h", k, wr_data_q[w0+k], dat[k]); end
      checks++; if (wr_strb_q[w0+k] !== 4'hF) begin errors++; $display("FAIL write_strb%0d got=%h exp=F", k, wr_strb_q[w0+k]); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL write_done_count got=%0d exp=1", done_cnt - d0); end
    checks++; if (hold_cnt - h0 != 4) begin errors++; $display("FAIL write_hold_cycles got=%0d exp=4", hold_cnt - h0); end
    checks++; if (bmem[2] !== 32'hC) begin errors++; $display("FAIL write_mem2 got=%h exp=0000000c", bmem[2]); end
  endtask

  task automatic test_read();
    int d0 = done_cnt;
    int h0 = hold_cnt;
    int r0 = rd_q.size();
    bit ok;
    rready = 1'b1;
    send_cmd(1'b0, 13'h1000, 11'd4);
    wait_done(d0, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL read_done_timeout got=none exp=pulse"); end
    wait_rd(r0 + 4, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL read_data_timeout got=%0d exp=4", rd_q.size() - r0); end
    repeat (2) tick();
    checks++; if (rd_q.size() - r0 != 4) begin errors++; $display("FAIL read_count got=%0d exp=4", rd_q.size() - r0); end
    for (int k = 0; k < 4 && (r0 + k) < rd_q.size(); k++) begin
      checks++; if (rd_q[r0+k] !== 32'hC0DE_0400 + k) begin errors++; $display("FAIL read_data%0d got=%h exp=%h", k, rd_q[r0+k], 32'hC0DE_0400 + k); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL read_done_count got=%0d exp=1", done_cnt - d0); end
    checks++; if (hold_cnt - h0 != 7) begin errors++; $display("FAIL read_hold_cycles got=%0d exp=7", hold_cnt - h0); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL read_drained got=%b exp=0", rvalid); end
  endtask

  task automatic test_backpressure();
    int d0 = done_cnt;
    int r0 = rd_q.size();
    int i0 = rd_issue_cnt;
    bit ok;
    rready = 1'b0;
    send_cmd(1'b0, 13'h1020, 11'd5);
    repeat (10) tick();
    checks++; if (rd_issue_cnt - i0 > 2) begin errors++; $display("FAIL bp_issued got=%0d exp<=2", rd_issue_cnt - i0); end
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL bp_rvalid got=%b exp=1", rvalid); end
    checks++; if (rdata !== 32'hC0DE_0408) begin errors++; $display("FAIL bp_head got=%h exp=c0de0408", rdata); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL bp_hold got=%b exp=1", cpu_hold); end
    rready = 1'b1;
    wait_done(d0, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout got=none exp=pulse"); end
    wait_rd(r0 + 5, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_data_timeout got=%0d exp=5", rd_q.size() - r0); end
    repeat (2) tick();
    checks++; if (rd_q.size() - r0 != 5) begin errors++; $display("FAIL bp_count got=%0d exp=5", rd_q.size() - r0); end
    for (int k = 0; k < 5 && (r0 + k) < rd_q.size(); k++) begin
      checks++; if (rd_q[r0+k] !== 32'hC0DE_0408 + k) begin errors++; $display("FAIL bp_data%0d got=%h exp=%h", k, rd_q[r0+k], 32'hC0DE_0408 + k); end
    end
  endtask

  task automatic test_wrap();
    int w0 = wr_addr_q.size();
    int d0 = done_cnt;
    bit ok;
    send_cmd(1'b1, 13'h0FFE, 11'd2);
    wvalid = 1'b1; wdata = 32'h1122_3344; wstrb = 4'h3;
    tick();
    wvalid = 1'b0;
    tick();
    wvalid = 1'b1; wdata = 32'h5566_7788; wstrb = 4'hF;
    tick();
    wvalid = 1'b0;
    wait_done(d0, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_done_timeout got=none exp=pulse"); end
    tick();
    checks++; if (wr_addr_q.size() - w0 != 2) begin errors++; $display("FAIL wrap_beats got=%0d exp=2", wr_addr_q.size() - w0); end
    if (wr_addr_q.size() - w0 >= 2) begin
      checks++; if (wr_addr_q[w0] !== 13'h0FFC) begin errors++; $display("FAIL wrap_addr0 got=%h exp=0ffc", wr_addr_q[w0]); end
      checks++; if (wr_addr_q[w0+1] !== 13'h0000) begin errors++; $display("FAIL wrap_addr1 got=%h exp=0000", wr_addr_q[w0+1]); end
      checks++; if (wr_strb_q[w0] !== 4'h3) begin errors++; $display("FAIL wrap_strb0 got=%h exp=3", wr_strb_q[w0]); end
    end
    checks++; if (bmem[11'h3FF] !== 32'hC0DE_3344) begin errors++; $display("FAIL wrap_mem_partial got=%h exp=c0de3344", bmem[11'h3FF]); end
    checks++; if (bmem[0] !== 32'h5566_7788) begin errors++; $display("FAIL wrap_mem0 got=%h exp=55667788", bmem[0]); end
  endtask

  task automatic test_len_zero();
    int w0 = wr_addr_q.size();
    int d0 = done_cnt;
    int h0 = hold_cnt;
    wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    send_cmd(1'b1, 13'h0100, 11'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL len0_done got=%b exp=1", done); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL len0_cmd_ready got=%b exp=1", cmd_ready); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL len0_done_single got=%b exp=0", done); end
    wvalid = 1'b0;
    repeat (2) tick();
    checks++; if (wr_addr_q.size() != w0) begin errors++; $display("FAIL len0_no_write got=%0d exp=0", wr_addr_q.size() - w0); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL len0_done_count got=%0d exp=1", done_cnt - d0); end
    checks++; if (hold_cnt != h0) begin errors++; $display("FAIL len0_hold got=%0d exp=0", hold_cnt - h0); end
  endtask

  task automatic test_reset_mid_read();
    int r0 = rd_q.size();
    int r1;
    int w0;
    int d0;
    bit ok;
    rready = 1'b1;
    send_cmd(1'b0, 13'h1040, 11'd6);
    wait_rd(r0 + 2, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_data_timeout got=%0d exp=2", rd_q.size() - r0); end
    #2 reset = 1'b1;
    #1;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid got=%b exp=0", rvalid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata got=%h exp=0", rdata); end
    checks++; if (shared_bram_addr !== 13'h0) begin errors++; $display("FAIL midrst_addr got=%h exp=0", shared_bram_addr); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL midrst_hold got=%b exp=0", cpu_hold); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL midrst_wready got=%b exp=0", wready); end
    repeat (2) tick();
    reset = 1'b0;
    r1 = rd_q.size();
    repeat (5) tick();
    checks++; if (rd_q.size() != r1) begin errors++; $display("FAIL midrst_stale_read got=%0d exp=0", rd_q.size() - r1); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_cmd_ready got=%b exp=1", cmd_ready); end
    w0 = wr_addr_q.size();
    d0 = done_cnt;
    send_cmd(1'b1, 13'h0040, 11'd1);
    wvalid = 1'b1; wdata = 32'h5A5A_5A5A; wstrb = 4'hF;
    tick();
    wvalid = 1'b0;
    wait_done(d0, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_next_timeout got=none exp=pulse"); end
    tick();
    checks++; if (wr_addr_q.size() - w0 != 1) begin errors++; $display("FAIL midrst_next_beats got=%0d exp=1", wr_addr_q.size() - w0); end
    checks++; if (bmem[11'h010] !== 32'h5A5A_5A5A) begin errors++; $display("FAIL midrst_next_mem got=%h exp=5a5a5a5a", bmem[11'h010]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_wrap();
    test_len_zero();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_host_port.md
BRAM_HOST_PORT -- requirements
Module: bram_host_port

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits.
REQ-002 Parameter SIZE, default 1024: words per BRAM region; LOGSIZE = clog2(SIZE).
REQ-003 Parameter NUM_COL, default 4: byte-write columns per word.
REQ-004 Port clk, input, 1: single clock; all state SHALL change on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Command channel SHALL be cmd_valid (in, 1), cmd_ready (out, 1), cmd_write (in, 1), cmd_addr (in, LOGSIZE+3; byte address), cmd_len (in, LOGSIZE+1; word count).
REQ-007 Write-data channel SHALL be wdata (in, WIDTH), wstrb (in, NUM_COL), wvalid (in, 1) and wready (out, 1).
REQ-008 Read-data channel SHALL be rdata (out, WIDTH), rvalid (out, 1) and rready (in, 1).
REQ-009 Processor-side ports SHALL be bram_din (out, WIDTH), shared_bram_addr (out, LOGSIZE+3), bram_wr_en (out, NUM_COL) and bram_dout (in, WIDTH).
REQ-010 Status ports SHALL be cpu_hold (out, 1; processor held while high) and done (out, 1; one-cycle completion pulse).

Function
REQ-011 The FSM SHALL use the states IDLE, WR, RD and RD_WAIT.
REQ-012 cmd_ready SHALL be high only in IDLE; a command is accepted on cmd_valid && cmd_ready.
REQ-013 On accept, the block SHALL latch cmd_addr with bits [1:0] forced to 0, latch cmd_len, and enter WR if cmd_write is set, else RD.
REQ-014 A command with cmd_len==0 SHALL remain in IDLE, pulse done on the next cycle and cause no port activity.
REQ-015 In WR, wready SHALL be high; each wvalid && wready SHALL drive bram_din=wdata, bram_wr_en=wstrb and shared_bram_addr=current address in that same cycle (combinational).
REQ-016 bram_wr_en SHALL be 0 in every cycle without an accepted write beat.
REQ-017 After each beat or issued read, the address SHALL advance by 4, with bits [LOGSIZE+1:2] wrapping modulo SIZE and bit LOGSIZE+2 (region select) held constant.
REQ-018 WR SHALL return to IDLE after the cmd_len-th beat, with done pulsed in the following cycle.
REQ-019 In RD, the block SHALL issue one address per cycle; bram_dout for an address issued in cycle N SHALL be captured in cycle N+1.
REQ-020 Read data SHALL pass through a 2-entry FIFO driving rdata/rvalid, and a read SHALL be issued only when FIFO occupancy plus the in-flight read count is less than 2.
REQ-021 A simultaneous FIFO push and pop SHALL keep occupancy unchanged, and rdata order SHALL equal issue order.
REQ-022 After the last address is issued, the FSM SHALL go to RD_WAIT, then to IDLE once the final word has been pushed, pulsing done in that cycle.
REQ-023 done SHALL NOT wait for the FIFO to drain, and the FIFO SHALL continue to drain while the FSM is in IDLE.
REQ-024 cpu_hold SHALL rise in the cycle after accept and fall in the cycle done pulses.
REQ-025 wvalid while not in WR, and rready while the FIFO is empty, SHALL be ignored.

Reset
REQ-026 Reset SHALL force state=IDLE, cmd_ready=1 (after reset deasserts), wready=0, rvalid=0, rdata=0, bram_wr_en=0, bram_din=0, shared_bram_addr=0, cpu_hold=0 and done=0, and SHALL clear FIFO occupancy and the in-flight flag.
REQ-027 Reset mid-command SHALL abandon the command; no write beat or read SHALL complete after reset asserts.

Structure
REQ-028 The FSM state enum and the region-select bit position SHALL reside in the shared processor definitions package.
REQ-029 The 2-entry read FIFO SHALL be one sub-module, bram_rd_fifo, parameterised by WIDTH.

Verification
REQ-030 Write: cmd_write=1, cmd_addr=0x000, len=3, wdata 0xA,0xB,0xC, wstrb=4'hF -> bram_wr_en=F at addresses 0x000, 0x004 and 0x008, done pulsed once, and cpu_hold high for exactly 4 cycles.
REQ-031 Read with rready held high: cmd_addr=0x1000 (LOGSIZE=10), len=4 -> rdata equals the bram_dout sequence for 0x1000–0x100C in order, and done pulses after the 4th capture.
REQ-032 Backpressure: rready=0 during a len=5 read -> at most 2 reads issued, no data lost once rready rises, and all 5 words delivered in order.
REQ-033 Wrap: cmd_addr=0x0FFC, len=2, write -> second beat at 0x0000 (region bit unchanged).
REQ-034 Edge: len=0 -> done pulse with no bram_wr_en; reset asserted mid-read after 2 beats -> all outputs return to their reset values immediately, and the next command is accepted normally.
